// File: rtl/decode_stage_p.sv
// decode_stage_p: ID stage with an 8-entry register file, immediate and destination decode, load-use detection and the ID/EX register.
// Latency: one cycle from the IF/ID inputs to the ID/EX outputs.
// Backpressure: freeze holds all state, including register-file writes; a load-use hazard raises stall_out and inserts a bubble.
// Optional build macro DECODE_RF_BYPASS_EN: register-file reads see a same-cycle write-back (write-through bypass).
module decode_stage_p #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] pc2_in,
    input  logic              valid_in,
    input  logic              halt_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [1:0]        reg_dst,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic [1:0]        imm_mode,
    input  logic              zero_ext,
    input  logic              wb_we,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              freeze,
    output logic              stall_out,
    output logic              err,
    output logic              valid_idex,
    output logic [DATA_W-1:0] pc_idex,
    output logic [DATA_W-1:0] pc2_idex,
    output logic [DATA_W-1:0] rd1_idex,
    output logic [DATA_W-1:0] rd2_idex,
    output logic [DATA_W-1:0] imm_idex,
    output logic [CTRL_W-1:0] ctrl_idex,
    output logic [2:0]        rt_idex,
    output logic [2:0]        wr_idex,
    output logic              regwr_idex,
    output logic              memrd_idex,
    output logic              halt_idex
);

    // Register file storage and the ID/EX pipeline register.
    logic [DATA_W-1:0] rf_q [8];

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] pc2_q, pc2_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [2:0]        rt_q, rt_d;
    logic [2:0]        wr_q, wr_d;
    logic              regwr_q, regwr_d;
    logic              memrd_q, memrd_d;
    logic              halt_q, halt_d;
    logic              err_q;

    logic [2:0]        rs_addr;
    logic [2:0]        rt_addr;
    logic              wb_we_eff;
    logic              imm_illegal;
    logic              ext_bit;

    // Opcode bits are consumed by the control unit, not here.
    logic              unused_opcode;
    assign unused_opcode = ^instr_in[15:11];

    assign rs_addr     = instr_in[10:8];
    assign rt_addr     = instr_in[7:5];
    assign wb_we_eff   = wb_we & ~freeze;
    assign imm_illegal = (imm_mode == 2'b11);
    assign ext_bit     = ~zero_ext;

    // Register file write port; a frozen pipeline must not retire write-backs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we_eff) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Combinational read ports, optionally forwarding the write-back in flight.
    always_comb begin
        rd1_d = rf_q[rs_addr];
        rd2_d = rf_q[rt_addr];
`ifdef DECODE_RF_BYPASS_EN
        if (wb_we_eff && (wb_addr == rs_addr)) begin
            rd1_d = wb_data;
        end
        if (wb_we_eff && (wb_addr == rt_addr)) begin
            rd2_d = wb_data;
        end
`endif
    end

    // Immediate generator: field width from imm_mode, fill bit from zero_ext.
    always_comb begin
        imm_d = '0;
        case (imm_mode)
            2'b00:   imm_d = {{(DATA_W-5){ext_bit & instr_in[4]}}, instr_in[4:0]};
            2'b01:   imm_d = {{(DATA_W-8){ext_bit & instr_in[7]}}, instr_in[7:0]};
            2'b10:   imm_d = {{(DATA_W-11){ext_bit & instr_in[10]}}, instr_in[10:0]};
            default: imm_d = '0;
        endcase
    end

    // Destination register select.
    always_comb begin
        wr_d = 3'd0;
        case (reg_dst)
            2'b00:   wr_d = instr_in[7:5];
            2'b01:   wr_d = instr_in[4:2];
            2'b10:   wr_d = instr_in[10:8];
            default: wr_d = 3'd7;
        endcase
    end

    // Load-use hazard against the load sitting in ID/EX; a flush kills the consumer so no stall is needed.
    assign stall_out = valid_in & valid_q & memrd_q & regwr_q & ~flush &
                       ((uses_rs & (wr_q == rs_addr)) | (uses_rt & (wr_q == rt_addr)));

    // Next ID/EX contents: bubble on flush or stall, otherwise capture with valid gating.
    always_comb begin
        valid_d = 1'b0;
        pc_d    = '0;
        pc2_d   = '0;
        ctrl_d  = '0;
        rt_d    = 3'd0;
        regwr_d = 1'b0;
        memrd_d = 1'b0;
        halt_d  = 1'b0;
        if (!flush && !stall_out) begin
            valid_d = valid_in;
            pc_d    = pc_in;
            pc2_d   = pc2_in;
            ctrl_d  = valid_in ? ctrl_in : '0;
            rt_d    = rt_addr;
            regwr_d = reg_write & valid_in;
            memrd_d = mem_read & valid_in;
            halt_d  = halt_in & valid_in;
        end
    end

    // ID/EX register; freeze holds it regardless of flush or stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            pc2_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            rt_q    <= 3'd0;
            wr_q    <= 3'd0;
            regwr_q <= 1'b0;
            memrd_q <= 1'b0;
            halt_q  <= 1'b0;
        end else if (!freeze) begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            pc2_q   <= pc2_d;
            ctrl_q  <= ctrl_d;
            rt_q    <= rt_d;
            regwr_q <= regwr_d;
            memrd_q <= memrd_d;
            halt_q  <= halt_d;
            if (flush || stall_out) begin
                rd1_q <= '0;
                rd2_q <= '0;
                imm_q <= '0;
                wr_q  <= 3'd0;
            end else begin
                rd1_q <= rd1_d;
                rd2_q <= rd2_d;
                imm_q <= imm_d;
                wr_q  <= wr_d;
            end
        end
    end

    // Sticky illegal-immediate flag, set by any real, unfrozen instruction using mode 11.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (valid_in && !freeze && imm_illegal) begin
            err_q <= 1'b1;
        end
    end

    assign err        = err_q;
    assign valid_idex = valid_q;
    assign pc_idex    = pc_q;
    assign pc2_idex   = pc2_q;
    assign rd1_idex   = rd1_q;
    assign rd2_idex   = rd2_q;
    assign imm_idex   = imm_q;
    assign ctrl_idex  = ctrl_q;
    assign rt_idex    = rt_q;
    assign wr_idex    = wr_q;
    assign regwr_idex = regwr_q;
    assign memrd_idex = memrd_q;
    assign halt_idex  = halt_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed and randomized checks of decode_stage_p against a behavioural model.
// Latency: model predicts the ID/EX contents one clock after each input set.
// Backpressure: freeze, flush and load-use stalls are exercised both directed and at random.
module tb_decode_stage_p;
    localparam int DW = 16;
    localparam int CW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   instr_in;
    logic [DW-1:0] pc_in, pc2_in;
    logic          valid_in, halt_in;
    logic [CW-1:0] ctrl_in;
    logic [1:0]    reg_dst;
    logic          reg_write, mem_read, uses_rs, uses_rt;
    logic [1:0]    imm_mode;
    logic          zero_ext, wb_we;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          flush, freeze;

    logic          stall_out, err, valid_idex;
    logic [DW-1:0] pc_idex, pc2_idex, rd1_idex, rd2_idex, imm_idex;
    logic [CW-1:0] ctrl_idex;
    logic [2:0]    rt_idex, wr_idex;
    logic          regwr_idex, memrd_idex, halt_idex;

    always #5 clk = ~clk;

    decode_stage_p #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .pc2_in(pc2_in),
        .valid_in(valid_in), .halt_in(halt_in), .ctrl_in(ctrl_in), .reg_dst(reg_dst),
        .reg_write(reg_write), .mem_read(mem_read), .uses_rs(uses_rs), .uses_rt(uses_rt),
        .imm_mode(imm_mode), .zero_ext(zero_ext), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .freeze(freeze), .stall_out(stall_out), .err(err),
        .valid_idex(valid_idex), .pc_idex(pc_idex), .pc2_idex(pc2_idex), .rd1_idex(rd1_idex),
        .rd2_idex(rd2_idex), .imm_idex(imm_idex), .ctrl_idex(ctrl_idex), .rt_idex(rt_idex),
        .wr_idex(wr_idex), .regwr_idex(regwr_idex), .memrd_idex(memrd_idex), .halt_idex(halt_idex)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state.
    logic [DW-1:0] m_rf [8];
    logic          m_valid, m_regwr, m_memrd, m_halt, m_err;
    logic [DW-1:0] m_pc, m_pc2, m_rd1, m_rd2, m_imm;
    logic [CW-1:0] m_ctrl;
    logic [2:0]    m_rt, m_wr;

    task automatic model_bubble();
        m_valid = 0; m_regwr = 0; m_memrd = 0; m_halt = 0;
        m_pc = 0; m_pc2 = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_ctrl = 0; m_rt = 0; m_wr = 0;
    endtask

    task automatic model_reset();
        model_bubble();
        m_err = 0;
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
    endtask

    // Immediate as an integer: take the low n bits, subtract 2^n when signed and negative.
    function automatic logic [DW-1:0] imm_ref(input logic [15:0] ins, input logic [1:0] mode, input logic zx);
        int n, v;
        if (mode == 2'b11) return '0;
        n = (mode == 2'b00) ? 5 : (mode == 2'b01) ? 8 : 11;
        v = int'(ins) & ((1 << n) - 1);
        if (!zx && v >= (1 << (n - 1))) v = v - (1 << n);
        return v[DW-1:0];
    endfunction

    // Destination: bit position of the 3-bit field per reg_dst, or the fixed link register.
    function automatic logic [2:0] wr_ref(input logic [15:0] ins, input logic [1:0] sel);
        int lsb_tab [3] = '{5, 2, 8};
        int v;
        if (sel == 2'b11) return 3'd7;
        v = (int'(ins) >> lsb_tab[sel]) & 7;
        return v[2:0];
    endfunction

    task automatic check_all(input string pfx);
        check_eq({pfx, ".valid"}, valid_idex, m_valid);
        check_eq({pfx, ".pc"}, pc_idex, m_pc);
        check_eq({pfx, ".pc2"}, pc2_idex, m_pc2);
        check_eq({pfx, ".rd1"}, rd1_idex, m_rd1);
        check_eq({pfx, ".rd2"}, rd2_idex, m_rd2);
        check_eq({pfx, ".imm"}, imm_idex, m_imm);
        check_eq({pfx, ".ctrl"}, ctrl_idex, m_ctrl);
        check_eq({pfx, ".rt"}, rt_idex, m_rt);
        check_eq({pfx, ".wr"}, wr_idex, m_wr);
        check_eq({pfx, ".regwr"}, regwr_idex, m_regwr);
        check_eq({pfx, ".memrd"}, memrd_idex, m_memrd);
        check_eq({pfx, ".halt"}, halt_idex, m_halt);
        check_eq({pfx, ".err"}, err, m_err);
    endtask

    // Called just after a falling edge with inputs set: checks stall, clocks once, checks ID/EX.
    task automatic do_cycle(input string pfx);
        logic [2:0]    rs, rt;
        logic          st, wbe;
        logic [DW-1:0] r1, r2;
        #1;
        rs = instr_in[10:8];
        rt = instr_in[7:5];
        st = valid_in && m_valid && m_memrd && m_regwr && !flush &&
             ((uses_rs && m_wr == rs) || (uses_rt && m_wr == rt));
        check_eq({pfx, ".stall"}, stall_out, st);
        wbe = wb_we && !freeze;
        r1 = m_rf[rs];
        r2 = m_rf[rt];
`ifdef DECODE_RF_BYPASS_EN
        if (wbe && wb_addr == rs) r1 = wb_data;
        if (wbe && wb_addr == rt) r2 = wb_data;
`endif
        @(posedge clk);
        if (!freeze) begin
            if (flush || st) begin
                model_bubble();
            end else begin
                m_valid = valid_in;
                m_pc    = pc_in;
                m_pc2   = pc2_in;
                m_rd1   = r1;
                m_rd2   = r2;
                m_imm   = imm_ref(instr_in, imm_mode, zero_ext);
                m_ctrl  = valid_in ? ctrl_in : '0;
                m_rt    = rt;
                m_wr    = wr_ref(instr_in, reg_dst);
                m_regwr = valid_in && reg_write;
                m_memrd = valid_in && mem_read;
                m_halt  = valid_in && halt_in;
            end
            if (valid_in && imm_mode == 2'b11) m_err = 1;
            if (wbe) m_rf[wb_addr] = wb_data;
        end
        #1;
        check_all(pfx);
        @(negedge clk);
    endtask

    task automatic set_idle();
        instr_in = 0; pc_in = 0; pc2_in = 0; valid_in = 0; halt_in = 0; ctrl_in = 0;
        reg_dst = 0; reg_write = 0; mem_read = 0; uses_rs = 0; uses_rt = 0;
        imm_mode = 0; zero_ext = 0; wb_we = 0; wb_addr = 0; wb_data = 0; flush = 0; freeze = 0;
    endtask

    // Put a load of R2 (reg_dst 00 -> instr[7:5]) into ID/EX.
    task automatic issue_load_r2();
        set_idle();
        valid_in = 1; mem_read = 1; reg_write = 1; reg_dst = 2'b00;
        instr_in = {5'd0, 3'd1, 3'd2, 5'd0};
        pc_in = 16'h0040; pc2_in = 16'h0042;
        do_cycle("load");
    endtask

    task automatic set_consumer_r2();
        set_idle();
        valid_in = 1; uses_rt = 1; reg_write = 1;
        instr_in = {5'd0, 3'd4, 3'd2, 5'd0};
        pc_in = 16'h0042; pc2_in = 16'h0044; ctrl_in = 15'h1A5;
    endtask

    logic [DW-1:0] saved_pc;
    logic [DW-1:0] saved_rd1;

    initial begin
        set_idle();
        rst = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        check_eq("reset.stall", stall_out, 0);
        rst = 1;

        // Write R3, then read it back through rd1.
        set_idle();
        wb_we = 1; wb_addr = 3; wb_data = 16'hBEEF;
        do_cycle("wr_r3");
        set_idle();
        valid_in = 1; reg_write = 1; uses_rs = 1; instr_in = 16'h0300;
        do_cycle("rd_r3");
        check_eq("rd1_beef", rd1_idex, 16'hBEEF);

        // Immediate forms.
        set_idle();
        valid_in = 1; instr_in = 16'h0016; imm_mode = 2'b00;
        do_cycle("imm5s");
        check_eq("imm5_sign", imm_idex, 16'hFFF6);
        zero_ext = 1;
        do_cycle("imm5z");
        check_eq("imm5_zero", imm_idex, 16'h0016);
        zero_ext = 0; instr_in = 16'h0400; imm_mode = 2'b10;
        do_cycle("imm11");
        check_eq("imm11_sign", imm_idex, 16'hFC00);
        check_eq("err_clear", err, 0);
        instr_in = 16'h00FF; imm_mode = 2'b11;
        do_cycle("imm_ill");
        check_eq("imm_ill_zero", imm_idex, 0);
        check_eq("err_set", err, 1);
        set_idle();
        do_cycle("err_hold1");
        do_cycle("err_hold2");
        check_eq("err_sticky", err, 1);

        // Load-use stall, bubble, then capture.
        issue_load_r2();
        set_consumer_r2();
        #1;
        check_eq("lu_stall", stall_out, 1);
        do_cycle("lu_bubble");
        check_eq("lu_bubble_valid", valid_idex, 0);
        #1;
        check_eq("lu_nostall", stall_out, 0);
        do_cycle("lu_capture");
        check_eq("lu_capture_valid", valid_idex, 1);
        check_eq("lu_capture_pc", pc_idex, 16'h0042);

        // Flush beats an active hazard and kills halt.
        issue_load_r2();
        set_consumer_r2();
        halt_in = 1; flush = 1;
        #1;
        check_eq("flush_stall", stall_out, 0);
        do_cycle("flush");
        check_eq("flush_valid", valid_idex, 0);
        check_eq("flush_halt", halt_idex, 0);

        // Freeze for three cycles with writes to R3 and changing inputs.
        set_idle();
        valid_in = 1; uses_rs = 1; instr_in = 16'h0300; pc_in = 16'h0100; pc2_in = 16'h0102;
        do_cycle("pre_freeze");
        saved_pc = pc_idex;
        saved_rd1 = rd1_idex;
        for (int i = 0; i < 3; i++) begin
            freeze = 1; wb_we = 1; wb_addr = 3; wb_data = 16'($urandom);
            instr_in = 16'($urandom); pc_in = 16'($urandom); flush = 1'(i == 1);
            do_cycle("freeze");
            check_eq("freeze_pc", pc_idex, saved_pc);
            check_eq("freeze_rd1", rd1_idex, saved_rd1);
        end
        set_idle();
        valid_in = 1; uses_rs = 1; instr_in = 16'h0300; pc_in = 16'h0200;
        do_cycle("unfreeze");
        check_eq("unfreeze_pc", pc_idex, 16'h0200);
        check_eq("unfreeze_r3", rd1_idex, 16'hBEEF);

        // Same-cycle write and read of R5 (R5 still holds its reset value).
        set_idle();
        wb_we = 1; wb_addr = 5; wb_data = 16'h1234; valid_in = 1; instr_in = 16'h0500;
        do_cycle("wr_rd_r5");
`ifdef DECODE_RF_BYPASS_EN
        check_eq("r5_bypass", rd1_idex, 16'h1234);
`else
        check_eq("r5_old", rd1_idex, 16'h0000);
`endif

        // Reset asserted mid-stall and mid-freeze.
        issue_load_r2();
        set_consumer_r2();
        freeze = 1;
        #2;
        rst = 0;
        #1;
        model_reset();
        check_all("mid_reset");
        check_eq("mid_reset.stall", stall_out, 0);
        @(negedge clk);
        rst = 1;
        set_idle();
        valid_in = 1; instr_in = 16'h0360;
        do_cycle("post_reset");
        check_eq("post_reset_r3", rd1_idex, 0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            instr_in  = 16'($urandom);
            if (m_valid && $urandom_range(3) == 0) instr_in[7:5] = m_wr;
            if (m_valid && $urandom_range(3) == 0) instr_in[10:8] = m_wr;
            pc_in     = 16'($urandom);
            pc2_in    = pc_in + 16'd2;
            valid_in  = ($urandom_range(99) < 80);
            halt_in   = ($urandom_range(99) < 10);
            ctrl_in   = 15'($urandom);
            reg_dst   = 2'($urandom);
            reg_write = 1'($urandom);
            mem_read  = ($urandom_range(99) < 35);
            uses_rs   = 1'($urandom);
            uses_rt   = 1'($urandom);
            imm_mode  = ($urandom_range(99) < 5) ? 2'b11 : 2'($urandom_range(2));
            zero_ext  = 1'($urandom);
            wb_we     = 1'($urandom);
            wb_addr   = 3'($urandom);
            wb_data   = 16'($urandom);
            flush     = ($urandom_range(99) < 10);
            freeze    = ($urandom_range(99) < 10);
            if ($urandom_range(199) == 0) begin
                #2;
                rst = 0;
                #1;
                model_reset();
                check_all("rnd_reset");
                @(negedge clk);
                rst = 1;
            end else begin
                do_cycle("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
